// File: rtl/inst_loader_if.sv
// Byte-stream input, RAM write port and status signals of the instruction loader.
// The loader itself uses the slave modport; the controlling side uses master.
interface inst_loader_if #(
   parameter int ADDR_WIDTH = 15
);
   logic                  start;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_enable;
   logic                  ram_write_enable;
   logic [31:0]           ram_write_data;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH:0]   words_loaded;

   modport slave (
      input  start, rx_data, rx_valid,
      output ram_addr, ram_enable, ram_write_enable, ram_write_data,
             busy, done, error, words_loaded
   );

   modport master (
      output start, rx_data, rx_valid,
      input  ram_addr, ram_enable, ram_write_enable, ram_write_data,
             busy, done, error, words_loaded
   );
endinterface

// File: rtl/inst_loader.sv
// Boot loader front end: assembles a little-endian word count and data words from a
// UART byte stream and writes the words sequentially into the instruction RAM.
module inst_loader #(
   parameter int ADDR_WIDTH = 15,
   parameter int BASE_ADDR  = 0
) (
   input  logic          clk,
   input  logic          rst,
   inst_loader_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
   // Largest acceptable word count; 33 bits so the 32-bit length is never truncated.
   localparam logic [32:0] LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

   typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;

   state_t                state, state_nxt;
   logic [1:0]            byte_cnt, byte_cnt_nxt;
   logic [31:0]           length, length_nxt;
   logic [23:0]           word_buf, word_buf_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [31:0]           wdata_q, wdata_nxt;
   logic [ADDR_WIDTH:0]   wl_q, wl_nxt, wl_inc;
   logic                  wr_q, wr_nxt;
   logic                  busy_q, busy_nxt;
   logic                  done_q, done_nxt;
   logic                  error_q, error_nxt;
   logic [31:0]           len_full, word_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         byte_cnt <= '0;
         length   <= '0;
         word_buf <= '0;
         addr_q   <= BASE_A;
         wdata_q  <= '0;
         wl_q     <= '0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         byte_cnt <= byte_cnt_nxt;
         length   <= length_nxt;
         word_buf <= word_buf_nxt;
         addr_q   <= addr_nxt;
         wdata_q  <= wdata_nxt;
         wl_q     <= wl_nxt;
         wr_q     <= wr_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         error_q  <= error_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      length_nxt   = length;
      word_buf_nxt = word_buf;
      addr_nxt     = addr_q;
      wdata_nxt    = wdata_q;
      wl_nxt       = wl_q;
      wr_nxt       = 1'b0;
      len_full     = {bus.rx_data, length[23:0]};
      word_full    = {bus.rx_data, word_buf};
      wl_inc       = wl_q + (ADDR_WIDTH+1)'(1);

      case (state)
         IDLE, DONE, ERR: begin
            if (bus.start) begin
               state_nxt    = LEN;
               byte_cnt_nxt = '0;
               wl_nxt       = '0;
               addr_nxt     = BASE_A;
            end
         end
         LEN: begin
            if (bus.rx_valid) begin
               byte_cnt_nxt = byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0:    length_nxt[7:0]   = bus.rx_data;
                  2'd1:    length_nxt[15:8]  = bus.rx_data;
                  2'd2:    length_nxt[23:16] = bus.rx_data;
                  default: begin
                     length_nxt = len_full;
                     if (len_full == 32'd0)            state_nxt = DONE;
                     else if ({1'b0, len_full} > LIMIT) state_nxt = ERR;
                     else                               state_nxt = DATA;
                  end
               endcase
            end
         end
         DATA: begin
            if (bus.rx_valid) begin
               byte_cnt_nxt = byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0:    word_buf_nxt[7:0]   = bus.rx_data;
                  2'd1:    word_buf_nxt[15:8]  = bus.rx_data;
                  2'd2:    word_buf_nxt[23:16] = bus.rx_data;
                  default: begin
                     // Address uses the count before this write; the count advances with it.
                     wr_nxt    = 1'b1;
                     wdata_nxt = word_full;
                     addr_nxt  = BASE_A + wl_q[ADDR_WIDTH-1:0];
                     wl_nxt    = wl_inc;
                     if (32'(wl_inc) == length) state_nxt = DONE;
                  end
               endcase
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt  = (state_nxt == LEN) || (state_nxt == DATA);
      done_nxt  = (state_nxt == DONE);
      error_nxt = (state_nxt == ERR);
   end

   assign bus.ram_addr         = addr_q;
   assign bus.ram_enable       = wr_q;
   assign bus.ram_write_enable = wr_q;
   assign bus.ram_write_data   = wdata_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.error            = error_q;
   assign bus.words_loaded     = wl_q;
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer-side front end for the instruction RAM.
- Receives a byte stream from the UART receiver, assembles 32-bit little-endian words, and writes them sequentially into one port of the dual-port instruction RAM.
- Used at boot to load a program image: a 4-byte word count followed by the words themselves.
- Reports busy, done and error to the core or bootloader control.

Parameters:
- ADDR_WIDTH, 15: width of the instruction RAM word address.
- BASE_ADDR, 0: word address of the first word written; must be < 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only when busy=0.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per byte; may be asserted every cycle.
- ram_addr  out  ADDR_WIDTH  word address to the RAM port.
- ram_enable  out  1  RAM port enable.
- ram_write_enable  out  1  RAM port write enable.
- ram_write_data  out  32  word to write.
- busy  out  1  high while in LEN or DATA.
- done  out  1  level; high after a successful load, until the next accepted start or rst.
- error  out  1  level; high after a rejected length, until the next accepted start or rst.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset values, all registered: state=IDLE; ram_enable=0; ram_write_enable=0; ram_addr=BASE_ADDR; ram_write_data=0; busy=0; done=0; error=0; words_loaded=0; byte counter=0; length=0.
- States: IDLE, LEN, DATA, DONE, ERR.
  - IDLE/DONE/ERR + start: go to LEN; clear done, error, words_loaded and the byte counter; set ram_addr=BASE_ADDR.
- Bytes with rx_valid=1 are ignored in IDLE, DONE and ERR.
- start while busy=1 is ignored.
- Byte assembly is little-endian: the first byte of each group of 4 goes to [7:0], the fourth to [31:24]. A 2-bit byte counter wraps 3->0.
- LEN collects 4 bytes into a 32-bit length register. Decision is taken on the 4th byte (accepted in cycle N); the new state is visible in cycle N+1:
  - length=0: go to DONE (done=1, busy=0). No write.
  - length > 2**ADDR_WIDTH - BASE_ADDR: go to ERR (error=1, busy=0). No write. The comparison uses the full 32-bit length, with no truncation.
  - otherwise: go to DATA.
- DATA: on the 4th byte of a word (accepted in cycle N), in cycle N+1 exactly:
  - ram_enable=1 and ram_write_enable=1 for one cycle;
  - ram_write_data = the assembled word;
  - ram_addr = BASE_ADDR + words_loaded (old value);
  - words_loaded increments in the same cycle.
- After each write pulse, ram_addr holds its value; it advances with the next write.
- On the last word (words_loaded+1 == length), the state becomes DONE in cycle N+1. The final write pulse and done=1 coincide in that cycle.
- ram_enable and ram_write_enable are never high outside a write pulse.
- Throughput: one byte per cycle sustained; one write per 4 accepted bytes; no backpressure and no byte loss.
- rst at any time, including mid-LEN or mid-DATA:
  - all state returns to reset values on the next edge; no write pulse is issued that cycle;
  - a partial word is discarded;
  - already-written RAM words are not altered.
- rst has priority over start and rx_valid in the same cycle.

Test Plan:
- start; bytes 02 00 00 00, 13 00 00 00, EF BE AD DE -> write addr 0 data 0x00000013, then write addr 1 data 0xDEADBEEF; done=1 in the cycle of the second write; words_loaded=2; busy=0.
- start; bytes 00 00 00 00 -> no ram_enable pulse; done=1 in the cycle after the 4th byte; words_loaded=0.
- BASE_ADDR=0, ADDR_WIDTH=15; length bytes 01 80 00 00 (0x8001) -> error=1, done=0, no writes. Then length bytes 00 80 00 00 (0x8000) is accepted and proceeds to DATA.
- start, then rx_valid asserted every cycle for 4+16 bytes with length 4 -> exactly 4 single-cycle write pulses, spaced 4 cycles apart, at addresses 0..3 with the correct words.
- Length 4; rst asserted after 2 words plus 2 bytes of the third -> next cycle all outputs are at reset values; no third write; further rx_valid bytes are ignored until start.
- rx_valid bytes before start -> ignored. A second start mid-DATA -> ignored, the load completes normally. With BASE_ADDR=0x100 and length 1 -> write at addr 0x100.
